// File: rtl/noise_channel_adder.sv
// Noise channel adder: joins each channel sample with one buffered noise
// sample, adds the (scaled) noise with saturation and presents the result
// through a single registered output stage.
//
// Handshake: a word moves on any interface only in a cycle where both
// valid and ready are high at the rising edge; once sig_out_valid is high,
// sig_out and sig_out_valid stay unchanged until sig_out_ready is seen.
// The noise input has no ready, so samples that find the FIFO full are
// dropped and counted.
module noise_channel_adder #(
    parameter int DATA_W      = 8,
    parameter int NOISE_W     = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SCALE_SHIFT = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [DATA_W-1:0]   sig_in,
    input  logic                sig_in_valid,
    output logic                sig_in_ready,
    input  logic [NOISE_W-1:0]  noise_in,
    input  logic                noise_in_valid,
    output logic [DATA_W-1:0]   sig_out,
    output logic                sig_out_valid,
    input  logic                sig_out_ready,
    output logic [15:0]         sat_count,
    output logic [15:0]         drop_count,
    output logic [31:0]         sample_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int SUM_W = DATA_W + SCALE_SHIFT + 2;

    // Clamp limits expressed in the wide sum domain.
    localparam logic signed [SUM_W-1:0] SUM_MAX =
        {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;

    logic [NOISE_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW:0]              wr_ptr;
    logic [AW:0]              rd_ptr;
    logic                     empty;
    logic                     full;
    logic                     push;
    logic                     pop;
    logic                     drop;
    logic                     accept;
    logic [NOISE_W-1:0]       noise_head;
    logic signed [SUM_W-1:0]  sig_ext;
    logic signed [SUM_W-1:0]  noise_ext;
    logic signed [SUM_W-1:0]  noise_scaled;
    logic signed [SUM_W-1:0]  sum;
    logic                     sat_hi;
    logic                     sat_lo;
    logic [DATA_W-1:0]        clamped;

    // FIFO status and the join/accept handshake decode.
    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        sig_in_ready = en && !empty && (!sig_out_valid || sig_out_ready);
        accept       = sig_in_valid && sig_in_ready;
        pop          = accept;
        push         = en && noise_in_valid && (!full || pop);
        drop         = en && noise_in_valid && full && !pop;
    end

    // Sign-extend both operands, scale the noise, add and clamp.
    always_comb begin
        noise_head   = fifo_mem[rd_ptr[AW-1:0]];
        sig_ext      = {{(SUM_W-DATA_W){sig_in[DATA_W-1]}}, sig_in};
        noise_ext    = {{(SUM_W-NOISE_W){noise_head[NOISE_W-1]}}, noise_head};
        noise_scaled = noise_ext << SCALE_SHIFT;
        sum          = sig_ext + noise_scaled;
        sat_hi       = (sum > SUM_MAX);
        sat_lo       = (sum < SUM_MIN);
        if (sat_hi) begin
            clamped = SUM_MAX[DATA_W-1:0];
        end else if (sat_lo) begin
            clamped = SUM_MIN[DATA_W-1:0];
        end else begin
            clamped = sum[DATA_W-1:0];
        end
    end

    // Noise storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= noise_in;
        end
    end

    // FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Registered output stage: load on accept, clear valid when drained.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sig_out       <= '0;
            sig_out_valid <= 1'b0;
        end else if (accept) begin
            sig_out       <= clamped;
            sig_out_valid <= 1'b1;
        end else if (sig_out_valid && sig_out_ready) begin
            sig_out_valid <= 1'b0;
        end
    end

    // Event counters: saturation and drop stick at all-ones, samples wrap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sat_count    <= '0;
            drop_count   <= '0;
            sample_count <= '0;
        end else begin
            if (accept && (sat_hi || sat_lo) && (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            if (accept) begin
                sample_count <= sample_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_noise_channel_adder.sv
// Bench for noise_channel_adder: directed scenarios followed by random
// traffic, checked against a queue-based behavioural model.
module tb_noise_channel_adder;

    localparam int DATA_W      = 8;
    localparam int NOISE_W     = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int SCALE_SHIFT = 0;
    localparam int MAX_V       = (1 << (DATA_W-1)) - 1;
    localparam int MIN_V       = -(1 << (DATA_W-1));

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                en = 1'b0;
    logic [DATA_W-1:0]   sig_in = '0;
    logic                sig_in_valid = 1'b0;
    logic                sig_in_ready;
    logic [NOISE_W-1:0]  noise_in = '0;
    logic                noise_in_valid = 1'b0;
    logic [DATA_W-1:0]   sig_out;
    logic                sig_out_valid;
    logic                sig_out_ready = 1'b0;
    logic [15:0]         sat_count;
    logic [15:0]         drop_count;
    logic [31:0]         sample_count;

    noise_channel_adder #(
        .DATA_W(DATA_W), .NOISE_W(NOISE_W),
        .FIFO_DEPTH(FIFO_DEPTH), .SCALE_SHIFT(SCALE_SHIFT)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .sig_in(sig_in), .sig_in_valid(sig_in_valid), .sig_in_ready(sig_in_ready),
        .noise_in(noise_in), .noise_in_valid(noise_in_valid),
        .sig_out(sig_out), .sig_out_valid(sig_out_valid), .sig_out_ready(sig_out_ready),
        .sat_count(sat_count), .drop_count(drop_count), .sample_count(sample_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [DATA_W-1:0] exp_q[$];
    int                nq[$];
    int                checks = 0;
    int                errors = 0;
    bit                armed = 1'b0;
    bit                m_valid = 1'b0;
    int                m_sat = 0;
    int                m_drop = 0;
    logic [31:0]       m_samples = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one step per cycle) ----------------
    always @(negedge clk) begin : model_blk
        bit exp_ready;
        bit acc;
        int s;
        int n;
        exp_ready = en && (nq.size() > 0) && (!m_valid || sig_out_ready);
        acc       = sig_in_valid && exp_ready;
        if (armed) begin
            check("sig_in_ready", longint'(sig_in_ready), longint'(exp_ready));
            check("sig_out_valid", longint'(sig_out_valid), longint'(m_valid));
            check("sat_count", longint'(sat_count), longint'(m_sat));
            check("drop_count", longint'(drop_count), longint'(m_drop));
            check("sample_count", longint'(sample_count), longint'(m_samples));
        end
        if (!rstn) begin
            nq.delete();
            exp_q.delete();
            m_valid   = 1'b0;
            m_sat     = 0;
            m_drop    = 0;
            m_samples = '0;
            armed     = 1'b1;
        end else begin
            if (acc) begin
                n = nq.pop_front();
                s = int'($signed(sig_in)) + n * (1 << SCALE_SHIFT);
                if (s > MAX_V || s < MIN_V) begin
                    if (m_sat != 65535) m_sat++;
                    s = (s > MAX_V) ? MAX_V : MIN_V;
                end
                exp_q.push_back(DATA_W'(s));
                m_samples = m_samples + 32'd1;
                m_valid   = 1'b1;
            end else if (m_valid && sig_out_ready) begin
                m_valid = 1'b0;
            end
            if (en && noise_in_valid) begin
                if (nq.size() < FIFO_DEPTH) nq.push_back(int'($signed(noise_in)));
                else if (m_drop != 65535) m_drop++;
            end
        end
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (armed && rstn && sig_out_valid) begin
            if (exp_q.size() == 0) begin
                check("sig_out_unexpected", 1, 0);
            end else begin
                check("sig_out", longint'(sig_out), longint'(exp_q[0]));
                if (sig_out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input bit r, input bit e, input bit sv, input int s,
                         input bit nv, input int n, input bit rdy);
        rstn           = r;
        en             = e;
        sig_in_valid   = sv;
        sig_in         = DATA_W'(s);
        noise_in_valid = nv;
        noise_in       = NOISE_W'(n);
        sig_out_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_sample();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return MAX_V;
        if (sel == 1) return MIN_V;
        return $urandom_range(0, (1 << DATA_W) - 1);
    endfunction

    initial begin
        // T1 reset
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("reset_sig_out", longint'(sig_out), 0);
        check("reset_ready", longint'(sig_in_ready), 0);
        drive(1, 1, 0, 0, 0, 0, 1);

        // T2 basic: noise +1 then 100 -> 101
        drive(1, 1, 0, 0, 1, 1, 1);
        drive(1, 1, 1, 100, 0, 0, 1);
        check("basic_sig_out", longint'(sig_out), 101);
        drive(1, 1, 0, 0, 0, 0, 1);

        // T3 saturation both directions
        drive(1, 1, 0, 0, 1, 1, 1);
        drive(1, 1, 0, 0, 1, -1, 1);
        drive(1, 1, 1, MAX_V, 0, 0, 1);
        drive(1, 1, 1, MIN_V, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 0, 1);
        check("sat_two", longint'(sat_count), 2);

        // T4 backpressure: one word pending, noise every cycle
        drive(1, 1, 0, 0, 1, 5, 1);
        drive(1, 1, 1, 10, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 1, 1, i, 1, i, 0);
        check("bp_drops", longint'(drop_count), 4);
        for (int i = 0; i < 8; i++) drive(1, 1, 1, 20 + i, 0, 0, 1);

        // T5 starvation then a single noise sample
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 7, 0, 0, 1);
        drive(1, 1, 1, 7, 1, 3, 1);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 7, 0, 0, 1);

        // en=0 with pending traffic
        drive(1, 1, 0, 0, 1, 2, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 9, 1, 9, 1);
        drive(1, 1, 1, 9, 0, 0, 1);

        // T6 mid-stream reset
        for (int i = 0; i < 6; i++) drive(1, 1, 1, 30 + i, 1, i, 1);
        drive(0, 1, 1, 50, 1, 1, 1);
        check("midrst_count", longint'(sample_count), 0);
        check("midrst_valid", longint'(sig_out_valid), 0);
        for (int i = 0; i < 6; i++) drive(1, 1, 1, 40 + i, 1, -i, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
                  $urandom_range(0, 1), rand_sample(),
                  ($urandom_range(0, 2) != 0), rand_sample(),
                  ($urandom_range(0, 9) < 7));
        end

        // Drain
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 0, 1);
        check("drain_empty", longint'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
